seven_seg_scanner: RTL

Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. It takes a packed hex word and sequences one digit per refresh slot. On top of plain scanning it adds:
- a double-buffered data load, committed only at frame boundaries so the display never tears;
- per-digit decimal points and digit enables;
- optional leading-zero blanking;
- PWM brightness control.

It sits between the application datapath and the board display pins, in place of the fixed eight-digit scanner.

---
 rtl/seven_seg_if.sv | 30 +++
 rtl/seven_seg_scanner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_if.sv
// Application-side bundle for the seven-segment scanner: buffered digit data,
// live display controls, and the registered pin/scan outputs.
interface seven_seg_if #(
   parameter int N_DIGITS = 8,
   parameter int PWM_BITS = 4
);
   localparam int IDX_W = $clog2(N_DIGITS);

   logic [4*N_DIGITS-1:0] hex_in;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   en_in;
   logic                  load;
   logic                  lz_blank;
   logic [PWM_BITS-1:0]   brightness;
   logic [6:0]            segments;
   logic                  dp;
   logic [N_DIGITS-1:0]   anodes;
   logic [IDX_W-1:0]      digit_idx;
   logic                  frame_done;

   modport master (
      output hex_in, dp_in, en_in, load, lz_blank, brightness,
      input  segments, dp, anodes, digit_idx, frame_done
   );

   modport slave (
      input  hex_in, dp_in, en_in, load, lz_blank, brightness,
      output segments, dp, anodes, digit_idx, frame_done
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-aligned
// double buffering, leading-zero blanking and PWM brightness.
//
// Load buffer FSM:
//   state       | meaning
//   BUF_EMPTY   | no pending data; active register is current
//   BUF_PENDING | pending register holds a load awaiting the next frame boundary
module seven_seg_scanner #(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int PWM_BITS    = 4
) (
   input logic       clk_sys,
   input logic       rst_n,
   seven_seg_if.slave bus
);
   localparam int IDX_W  = $clog2(N_DIGITS);
   localparam int PCNT_W = $clog2(REFRESH_DIV);

   typedef enum logic {BUF_EMPTY, BUF_PENDING} buf_state_t;

   buf_state_t buf_state, buf_next;

   logic [PCNT_W-1:0]     pcnt;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [IDX_W-1:0]      digit_idx;
   logic                  frame_done;
   logic                  tick;
   logic                  boundary;
   logic                  commit_direct;
   logic                  commit_pending;

   logic [4*N_DIGITS-1:0] pending_hex, active_hex;
   logic [N_DIGITS-1:0]   pending_dp, active_dp;
   logic [N_DIGITS-1:0]   pending_en, active_en;

   logic [N_DIGITS:0]     zero_tail;
   logic [3:0]            cur_hex;
   logic                  cur_dp;
   logic                  cur_en;
   logic                  cur_lz;
   logic                  pwm_on;
   logic [6:0]            seg_d, seg_q;
   logic                  dp_d, dp_q;
   logic [N_DIGITS-1:0]   an_d, an_q;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: hex_to_seg = 7'b1000000;
         4'h1: hex_to_seg = 7'b1111001;
         4'h2: hex_to_seg = 7'b0100100;
         4'h3: hex_to_seg = 7'b0110000;
         4'h4: hex_to_seg = 7'b0011001;
         4'h5: hex_to_seg = 7'b0010010;
         4'h6: hex_to_seg = 7'b0000010;
         4'h7: hex_to_seg = 7'b1111000;
         4'h8: hex_to_seg = 7'b0000000;
         4'h9: hex_to_seg = 7'b0010000;
         4'hA: hex_to_seg = 7'b0001000;
         4'hB: hex_to_seg = 7'b0000011;
         4'hC: hex_to_seg = 7'b1000110;
         4'hD: hex_to_seg = 7'b0100001;
         4'hE: hex_to_seg = 7'b0000110;
         default: hex_to_seg = 7'b0001110;
      endcase
   endfunction

   assign tick     = (pcnt == PCNT_W'(REFRESH_DIV - 1));
   assign boundary = tick && (digit_idx == IDX_W'(N_DIGITS - 1));

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pcnt       <= '0;
         pwm_cnt    <= '0;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
         frame_done <= boundary;
         if (tick) begin
            pcnt <= '0;
            if (digit_idx == IDX_W'(N_DIGITS - 1)) digit_idx <= '0;
            else                                    digit_idx <= digit_idx + IDX_W'(1);
         end else begin
            pcnt <= pcnt + PCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) buf_state <= BUF_EMPTY;
      else        buf_state <= buf_next;
   end

   // A boundary always empties the buffer: a coincident load bypasses straight to active.
   always_comb begin
      buf_next = buf_state;
      if (boundary)      buf_next = BUF_EMPTY;
      else if (bus.load) buf_next = BUF_PENDING;
   end

   always_comb begin
      commit_direct  = boundary && bus.load;
      commit_pending = boundary && !bus.load && (buf_state == BUF_PENDING);
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pending_hex <= '0;
         pending_dp  <= '0;
         pending_en  <= '0;
         active_hex  <= '0;
         active_dp   <= '0;
         active_en   <= '0;
      end else begin
         if (bus.load) begin
            pending_hex <= bus.hex_in;
            pending_dp  <= bus.dp_in;
            pending_en  <= bus.en_in;
         end
         if (commit_direct) begin
            active_hex <= bus.hex_in;
            active_dp  <= bus.dp_in;
            active_en  <= bus.en_in;
         end else if (commit_pending) begin
            active_hex <= pending_hex;
            active_dp  <= pending_dp;
            active_en  <= pending_en;
         end
      end
   end

   // zero_tail[k] is set when digit k and every more-significant digit are zero.
   always_comb begin
      zero_tail           = '0;
      zero_tail[N_DIGITS] = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--)
         zero_tail[k] = zero_tail[k+1] && (active_hex[4*k +: 4] == 4'h0);
   end

   always_comb begin
      cur_hex = 4'h0;
      cur_dp  = 1'b0;
      cur_en  = 1'b0;
      cur_lz  = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (digit_idx == IDX_W'(k)) begin
            cur_hex = active_hex[4*k +: 4];
            cur_dp  = active_dp[k];
            cur_en  = active_en[k];
            cur_lz  = bus.lz_blank && (k > 0) && zero_tail[k];
         end
      end
   end

   always_comb begin
      pwm_on = (pwm_cnt <= bus.brightness);
      an_d   = '1;
      seg_d  = 7'h7F;
      dp_d   = 1'b1;
      if (cur_en) begin
         if (pwm_on) an_d[digit_idx] = 1'b0;
         seg_d = cur_lz ? 7'h7F : hex_to_seg(cur_hex);
         dp_d  = ~cur_dp;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign bus.segments   = seg_q;
   assign bus.dp         = dp_q;
   assign bus.anodes     = an_q;
   assign bus.digit_idx  = digit_idx;
   assign bus.frame_done = frame_done;
endmodule
